seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Upstream stage of the 4-digit seven-segment path. Converts a binary score into four packed BCD digits and generates the time-multiplexed digit select.
- Its `nums[15:0]` and `s[1:0]` outputs connect directly to `seg_mux`. `seg_mux` turns them into segment and anode drive.
- Conversion is sequential double-dabble, one bit per cycle, so no wide combinational divider sits in the game clock domain.

Parameters:
- `BIN_W`, 14: width of the binary input. 14 bits covers 0..16383.
- `REFRESH_DIV`, 100000: clock cycles per digit slot. At 100 MHz this gives 1 kHz per digit and a 250 Hz full-frame rate. Legal range is ≥2.
- `MAX_VAL`, 9999: saturation limit. It is the largest value that fits in 4 BCD digits.

Ports:
- `clk`  input  1  system clock. The block uses this single clock only.
- `rst`  input  1  reset, asynchronous and active-high.
- `value`  input  `BIN_W`  binary number to display. Sampled only on an accepted load.
- `load`  input  1  single-cycle request to convert `value`. Ignored while `busy` = 1.
- `busy`  output  1  high while a conversion is in progress.
- `nums`  output  16  packed BCD, digit 0 in [3:0] through digit 3 in [15:12]. Feeds `seg_mux.nums`.
- `s`  output  2  current digit select, counting 0→1→2→3→0. Feeds `seg_mux.s`.
- `overflow`  output  1  high when the last accepted `value` exceeded `MAX_VAL`.

Behaviour:

Reset (async assert, released synchronously to `clk`):
- `nums` = 16'h0000, `s` = 2'b00, `busy` = 0, `overflow` = 0.
- Prescaler = 0, FSM = IDLE.

Conversion FSM states: IDLE, SHIFT, DONE.
- **IDLE:**
  - On `load`=1, capture `min(value, MAX_VAL)` into the shift register and `(value > MAX_VAL)` into a pending overflow flag.
  - Clear the 16-bit BCD scratch, set bit counter = `BIN_W`, set `busy`=1, go to SHIFT.
- **SHIFT:** one iteration per cycle.
  - For each scratch nibble ≥5, add 3 to it.
  - Then left-shift {scratch, binary} by one.
  - Decrement the counter. When it reaches 0, go to DONE.
- **DONE:**
  - Copy scratch to `nums` and the pending flag to `overflow`.
  - Clear `busy`, return to IDLE.

Conversion timing:
- Latency: `load` sampled at edge N → `busy` high after edge N → `nums` updated at edge N+`BIN_W`+1. With the default that is 15 cycles.
- The next load is accepted at edge N+`BIN_W`+2, i.e. the cycle after `busy` drops.
- `nums` holds the previous result throughout the conversion and changes in a single cycle, so no partial digits are displayed.
- `load` while `busy`=1 is dropped. It is not queued.
- A load that arrives on the same edge as the DONE→IDLE transition is also dropped, because FSM ≠ IDLE on that edge.
- Add-3 arithmetic is per nibble, 4 bits wide. No nibble ever exceeds 9 after the shift, because the input is saturated first.

Scan timing:
- The prescaler counts 0..`REFRESH_DIV`-1 and then wraps to 0.
- On each wrap, `s` increments modulo 4. So `s` changes exactly once every `REFRESH_DIV` cycles, and 2'b11 wraps to 2'b00.
- Scanning is free-running and independent of conversion state.

Mid-operation reset:
- Any `rst` assertion aborts the conversion immediately. All outputs return to their reset values.
- No stale scratch value is ever committed to `nums`.

Decomposition:
- Shared display package, containing:
  - `SEG_DIGITS` = 4
  - `BCD_W` = 4
  - `SEG_MAX_VAL` = 9999
  - `SEG_REFRESH_DIV` default
  - the FSM state encoding (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2)
- Sub-modules:
  - `bin2bcd_seq` owns the FSM, saturation, the shift/add-3 datapath and the `load`/`busy`/`nums`/`overflow` ports.
  - The prescaler and the `s` counter stay in the top level.

Test Plan:
1. Reset, then `load`=1 with `value`=1234 → `busy`=1 for 15 cycles; `nums`=16'h1234 at cycle 15; `overflow`=0; `busy`=0 at cycle 15.
2. `value`=0, then `value`=9999 → `nums`=16'h0000, then 16'h9999; `overflow`=0 both times.
3. `value`=10000, then `value`=16383 → `nums`=16'h9999 and `overflow`=1 each time. A following load of 42 → `nums`=16'h0042 and `overflow`=0.
4. Load 1234, then pulse `load` with 5678 at cycles 3 and 15 (DONE edge) → both pulses ignored and `nums` ends at 16'h1234. A load of 5678 at cycle 16 → `nums`=16'h5678 at cycle 31.
5. `REFRESH_DIV`=4 → after reset, `s` = 0,0,0,0,1,1,1,1,2,…,3,3,3,3,0. `s` is unchanged by concurrent loads.
6. Load 8765, assert `rst` at cycle 7 for 2 cycles → `nums`=0, `busy`=0, `s`=0 immediately. After release, a load of 8765 → `nums`=16'h8765.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants, FSM encoding and BCD helper for the 4-digit seven-segment display path.
// No latency or backpressure of its own; consumed by seg_scan_driver and bin2bcd_seq.
package seg_scan_driver_pkg;

    localparam int SEG_DIGITS      = 4;
    localparam int BCD_W           = 4;
    localparam int SEG_MAX_VAL     = 9999;
    localparam int SEG_REFRESH_DIV = 100000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_e;

    // Double-dabble correction: a digit of 5 or more would overflow past 9 once doubled.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] n);
        return (n >= BCD_W'(5)) ? n + BCD_W'(3) : n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential saturating binary-to-BCD converter, one bit per cycle; result lands BIN_W+1 edges after load.
// Backpressure: busy is high while converting and any load seen outside IDLE is dropped, not queued.
module bin2bcd_seq
    import seg_scan_driver_pkg::*;
#(
    parameter int BIN_W   = 14,
    parameter int MAX_VAL = SEG_MAX_VAL
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BIN_W-1:0]            value,
    input  logic                        load,
    output logic                        busy,
    output logic [SEG_DIGITS*BCD_W-1:0] nums,
    output logic                        overflow
);

    localparam int NUM_W = SEG_DIGITS * BCD_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_VAL);

    bcd_state_e       state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [NUM_W-1:0] scr_q, scr_d;
    logic [NUM_W-1:0] scr_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [NUM_W-1:0] nums_q, nums_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        scr_adj = '0;
        for (int i = 0; i < SEG_DIGITS; i++) begin
            scr_adj[i*BCD_W +: BCD_W] = bcd_add3(scr_q[i*BCD_W +: BCD_W]);
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        nums_d     = nums_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    bin_d      = (value > MAX_B) ? MAX_B : value;
                    ovf_pend_d = (value > MAX_B);
                    scr_d      = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {scr_d, bin_d} = {scr_adj, bin_q} << 1;
                cnt_d          = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Single-cycle commit keeps the display from ever showing partial digits.
                nums_d  = scr_q;
                ovf_d   = ovf_pend_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            nums_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            nums_q     <= nums_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign nums     = nums_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Score-to-BCD conversion plus free-running digit select for seg_mux; s advances every REFRESH_DIV cycles.
// Conversion result appears BIN_W+1 edges after an accepted load; loads while busy are dropped.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = SEG_REFRESH_DIV,
    parameter int MAX_VAL     = SEG_MAX_VAL
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BIN_W-1:0]            value,
    input  logic                        load,
    output logic                        busy,
    output logic [SEG_DIGITS*BCD_W-1:0] nums,
    output logic [1:0]                  s,
    output logic                        overflow
);

    localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       s_q, s_d;

    bin2bcd_seq #(
        .BIN_W   (BIN_W),
        .MAX_VAL (MAX_VAL)
    ) u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .nums     (nums),
        .overflow (overflow)
    );

    // Scan is free-running and deliberately blind to conversion state.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        s_d   = s_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            s_d   = s_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            s_q   <= 2'b00;
        end else begin
            pre_q <= pre_d;
            s_q   <= s_d;
        end
    end

    assign s = s_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with a short refresh period (REFRESH_DIV=4).
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic [15:0] nums;
    logic [1:0]  s;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    seg_scan_driver #(
        .BIN_W       (14),
        .REFRESH_DIV (4),
        .MAX_VAL     (9999)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .nums     (nums),
        .s        (s),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one load, then checks busy width, held-previous-result, final nums and overflow.
    task automatic convert(input string tag, input logic [13:0] v, input logic [15:0] prev,
                           input logic [15:0] exp_nums, input logic exp_ovf);
        int busy_cnt;
        int changed;
        busy_cnt = 0;
        changed  = 0;
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
        while (busy === 1'b1 && busy_cnt < 40) begin
            busy_cnt++;
            if (nums !== prev) changed++;
            step();
        end
        chk({tag, "_busy_cycles"}, busy_cnt, 15);
        chk({tag, "_held"}, changed, 0);
        chk({tag, "_nums"}, {16'h0, nums}, {16'h0, exp_nums});
        chk({tag, "_ovf"}, {31'h0, overflow}, {31'h0, exp_ovf});
    endtask

    initial begin
        rst   = 1'b1;
        value = '0;
        load  = 1'b0;
        #12;
        chk("rst_nums", {16'h0, nums}, 32'h0);
        chk("rst_s", {30'h0, s}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);
        step();
        rst = 1'b0;
        step();

        convert("t1_1234", 14'd1234, 16'h0000, 16'h1234, 1'b0);
        convert("t2_0", 14'd0, 16'h1234, 16'h0000, 1'b0);
        convert("t2_9999", 14'd9999, 16'h0000, 16'h9999, 1'b0);
        convert("t3_10000", 14'd10000, 16'h9999, 16'h9999, 1'b1);
        convert("t3_16383", 14'd16383, 16'h9999, 16'h9999, 1'b1);
        convert("t3_42", 14'd42, 16'h9999, 16'h0042, 1'b0);

        // Loads during the conversion and on the DONE edge must be dropped.
        value = 14'd1234;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk("t4_busy_n", {31'h0, busy}, 32'h1);
        step();
        step();
        value = 14'd5678;
        load  = 1'b1;
        step();
        load  = 1'b0;
        for (int i = 0; i < 11; i++) step();
        chk("t4_busy_n14", {31'h0, busy}, 32'h1);
        chk("t4_held_n14", {16'h0, nums}, 32'h0042);
        value = 14'd5678;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk("t4_done_nums", {16'h0, nums}, 32'h1234);
        chk("t4_done_busy", {31'h0, busy}, 32'h0);
        step();
        chk("t4_no_requeue", {31'h0, busy}, 32'h0);
        convert("t4_5678", 14'd5678, 16'h1234, 16'h5678, 1'b0);

        // Reset mid-conversion, then scan sequence from reset with a concurrent load.
        value = 14'd8765;
        load  = 1'b1;
        step();
        load  = 1'b0;
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        #1;
        chk("t6_rst_nums", {16'h0, nums}, 32'h0);
        chk("t6_rst_busy", {31'h0, busy}, 32'h0);
        chk("t6_rst_s", {30'h0, s}, 32'h0);
        step();
        step();
        rst = 1'b0;
        chk("t6_rel_nums", {16'h0, nums}, 32'h0);
        chk("t5_s_k0", {30'h0, s}, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            if (k == 2) begin
                value = 14'd8765;
                load  = 1'b1;
            end
            step();
            load = 1'b0;
            chk($sformatf("t5_s_k%0d", k), {30'h0, s}, (k / 4) % 4);
        end
        chk("t6_pre_commit", {16'h0, nums}, 32'h0);
        step();
        chk("t6_8765_nums", {16'h0, nums}, 32'h8765);
        chk("t6_8765_busy", {31'h0, busy}, 32'h0);
        chk("t6_8765_ovf", {31'h0, overflow}, 32'h0);
        chk("t5_s_k17", {30'h0, s}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
